// File: rtl/g15_photo_tape_source_if.sv
// Host loading bus for the G-15 photo tape source.
// The host writes 5-bit frames and sets the tape length.
interface g15_photo_tape_source_if #(
   parameter int ADDR_W = 13
);
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [4:0]        host_data;
   logic              host_len_we;
   logic [ADDR_W:0]   host_len;

   modport master (
      output host_we, host_addr, host_data,
      output host_len_we, host_len
   );

   modport slave (
      input host_we, host_addr, host_data,
      input host_len_we, host_len
   );
endinterface

// File: rtl/g15_photo_tape_source.sv
// Paper-tape image source for the G-15 photoelectric reader.
// Plays a host-loaded frame image forward or backward at tape speed.
module g15_photo_tape_source #(
   parameter int ADDR_W      = 13,
   parameter int HOLE_CYCLES = 144,
   parameter int GAP_CYCLES  = 288
) (
   input  logic                       CLOCK,
   input  logic                       rst,
   g15_photo_tape_source_if.slave     host,
   input  logic                       tape_fwd,
   input  logic                       tape_rev,
   output logic [4:0]                 photo,
   output logic                       permit,
   output logic [ADDR_W:0]            pos,
   output logic                       at_start,
   output logic                       at_end,
   output logic                       busy
);

   localparam int DEPTH   = 1 << ADDR_W;
   localparam int CNT_MAX = (GAP_CYCLES > HOLE_CYCLES) ?
                            GAP_CYCLES : HOLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLE_LD = CNT_W'(HOLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GAP  = 2'd1,
      HOLE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W:0]   pos_q, pos_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [4:0]        photo_q, photo_d;
   logic              permit_q, permit_d;
   logic              dir_q, dir_d;

   logic [4:0]        mem [DEPTH];
   logic [4:0]        rd_q;

   logic              idle;
   logic              fwd_ok;
   logic              rev_ok;
   logic              run_ok;
   logic              cont_ok;
   logic [ADDR_W:0]   pos_up;
   logic [ADDR_W:0]   pos_dn;
   logic [ADDR_W:0]   pos_nx;
   logic [ADDR_W:0]   len_sat;
   logic              wr_en;
   logic              len_ld;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;

   // Motion decode, host gating and read address selection
   always_comb begin
      idle    = (state_q == IDLE);
      fwd_ok  = tape_fwd & ~tape_rev & (pos_q < len_q);
      rev_ok  = tape_rev & ~tape_fwd & (pos_q != '0);
      run_ok  = dir_q ? rev_ok : fwd_ok;
      pos_up  = pos_q + 1'b1;
      pos_dn  = pos_q - 1'b1;
      pos_nx  = dir_q ? pos_dn : pos_up;
      cont_ok = dir_q ?
                (tape_rev & ~tape_fwd & (pos_nx != '0)) :
                (tape_fwd & ~tape_rev & (pos_nx < len_q));
      len_sat = (host.host_len > LEN_MAX) ? LEN_MAX : host.host_len;
      wr_en   = idle & host.host_we;
      len_ld  = idle & host.host_len_we;
      rd_en   = (state_q == GAP) & run_ok & (cnt_q == CNT_ONE);
      rd_addr = dir_q ? pos_dn[ADDR_W-1:0] : pos_q[ADDR_W-1:0];
   end

   // Tape FSM: gap/hole timing, position stepping, run-off and host loads
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pos_d    = pos_q;
      len_d    = len_q;
      photo_d  = photo_q;
      dir_d    = dir_q;
      permit_d = (len_q != '0) &
                 ~(host.host_we | host.host_len_we);
      unique case (state_q)
         IDLE: begin
            photo_d = '0;
            if (len_ld) begin
               len_d = len_sat;
               pos_d = '0;
            end else if (fwd_ok | rev_ok) begin
               dir_d   = rev_ok;
               cnt_d   = GAP_LD;
               state_d = GAP;
            end
         end
         GAP: begin
            photo_d = '0;
            if (!run_ok) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               photo_d = rd_q;
               cnt_d   = HOLE_LD;
               state_d = HOLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HOLE: begin
            if (!run_ok) begin
               photo_d = '0;
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               photo_d = '0;
               pos_d   = pos_nx;
               if (cont_ok) begin
                  cnt_d   = GAP_LD;
                  state_d = GAP;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            photo_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State registers
   always_ff @(posedge CLOCK or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pos_q    <= '0;
         len_q    <= '0;
         photo_q  <= '0;
         permit_q <= 1'b0;
         dir_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pos_q    <= pos_d;
         len_q    <= len_d;
         photo_q  <= photo_d;
         permit_q <= permit_d;
         dir_q    <= dir_d;
      end
   end

   // Frame RAM with synchronous read, contents survive reset
   always_ff @(posedge CLOCK) begin
      if (wr_en) mem[host.host_addr] <= host.host_data;
      if (rd_en) rd_q <= mem[rd_addr];
   end

   assign photo    = photo_q;
   assign permit   = permit_q;
   assign pos      = pos_q;
   assign at_start = (pos_q == '0);
   assign at_end   = (pos_q == len_q);
   assign busy     = (state_q != IDLE);

endmodule

// File: doc/g15_photo_tape_source.md
Name: g15_photo_tape_source

Overview:
- Paper-tape image source for the built-in photoelectric reader.
- Sits directly upstream of the G-15 top level: drives its PL6_PHOTO1..5 and PHOTO_READER_PERMIT inputs, and consumes its PL6_PHOTO_TAPE_FWD/REV motor commands.
- Stores a host-loaded tape image of 5-bit frames and plays it forward or backward at tape speed, in units of the machine bit clock.

Parameters:
- ADDR_W, 13, frame address width; capacity 2**ADDR_W frames.
- HOLE_CYCLES, 144, CLOCK cycles a frame's holes are presented, >=1.
- GAP_CYCLES, 288, CLOCK cycles of blank tape between frames, >=2.

Ports:
- CLOCK  in  1  machine bit clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- tape_fwd  in  1  PL6_PHOTO_TAPE_FWD from the G-15 top level.
- tape_rev  in  1  PL6_PHOTO_TAPE_REV from the G-15 top level.
- host_we  in  1  frame write strobe.
- host_addr  in  ADDR_W  frame address.
- host_data  in  5  frame bits; bit0 -> PHOTO1 ... bit4 -> PHOTO5.
- host_len_we  in  1  load tape length and rewind.
- host_len  in  ADDR_W+1  number of valid frames, 0..2**ADDR_W.
- photo  out  5  PL6_PHOTO5..1 levels; 1 = hole.
- permit  out  1  PHOTO_READER_PERMIT.
- pos  out  ADDR_W+1  current tape position, 0..len.
- at_start  out  1  pos==0.
- at_end  out  1  pos==len.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, async): state IDLE, photo=0, permit=0, pos=0, len=0, at_start=1, at_end=1, busy=0. Frame RAM contents are not cleared.
- Motion decode, per cycle:
  - go_fwd = tape_fwd & ~tape_rev & (pos<len).
  - go_rev = tape_rev & ~tape_fwd & (pos>0).
  - Both asserted = stop.
- Frame numbering:
  - Forward reads frame[pos], then pos <= pos+1.
  - Reverse reads frame[pos-1], then pos <= pos-1.
- FSM states: IDLE, GAP, HOLE. One down-counter cnt.
  - IDLE: photo=0. On go_fwd|go_rev, latch dir, cnt <= GAP_CYCLES-1, go to GAP.
  - GAP: photo=0; cnt decrements.
    - When cnt==1, issue the synchronous RAM read at the dir-selected address.
    - When cnt==0, load photo <= read data, cnt <= HOLE_CYCLES-1, go to HOLE.
  - HOLE: photo holds the frame; cnt decrements. When cnt==0:
    - photo <= 0 and pos updates per dir.
    - If the motion for the same dir is still valid against the new pos, go to GAP with cnt <= GAP_CYCLES-1; else go to IDLE.
  - Frame period is GAP_CYCLES+HOLE_CYCLES cycles. The first hole appears GAP_CYCLES cycles after the motion command is sampled.
- Motion lost mid-frame (command drop, both asserted, or direction reversal):
  - In GAP or HOLE, go to IDLE next cycle, photo <= 0, pos unchanged. The interrupted frame is re-read on restart.
  - A reversal therefore always passes through one IDLE cycle.
- permit = (len!=0) & ~(host write activity this cycle). It is registered, so it lags one cycle.
- Host writes:
  - host_we writes RAM only while IDLE; it is ignored otherwise.
  - host_len_we while IDLE: len <= host_len, pos <= 0. Ignored otherwise.
  - host_len values > 2**ADDR_W saturate to 2**ADDR_W.
  - host_we and host_len_we in the same cycle: both take effect.
- at_start and at_end are combinational from pos and len.
- Empty tape (len=0): never leaves IDLE.
- Run-off: forward stops at pos==len; reverse stops at pos==0. Outputs are 0 at both ends.

Test Plan:
- Reset mid-HOLE (GAP=4, HOLE=2, frame 0x15 showing): assert rst -> photo=0, pos=0, state IDLE in the same cycle, permit=0.
- Forward playback (GAP=4, HOLE=2, len=3, frames 0x01,0x1F,0x0A; assert tape_fwd at cycle 0):
  - photo=0x01 for cycles 4-5, 0x1F for cycles 10-11, 0x0A for cycles 16-17.
  - pos ends at 3, at_end=1, busy drops at cycle 18.
- Reverse from pos=3, same tape: frames appear in order 0x0A, 0x1F, 0x01; pos=0; at_start=1; IDLE.
- Interrupt: tape_fwd dropped during the first HOLE -> photo=0 next cycle, pos stays 0. Reassert -> 0x01 replays after 4 GAP cycles.
- tape_fwd and tape_rev both high -> state stays IDLE, photo=0. host_we during motion -> RAM unchanged, verified by read-back playback.
- len=0 with tape_fwd high for 100 cycles -> busy=0, permit=0, photo=0.
